// File: rtl/alu_pkg.sv
// Shared opcodes, sequencer state type and opcode helpers for the nibble ALU sequencer.
// Latency: none (declarations only).
// Backpressure: not applicable.
package alu_pkg;

  localparam logic [2:0] OP_NOT = 3'b000;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  // Only ADD and SUB chain a carry/borrow between nibbles.
  function automatic logic is_arith(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/nibble_lane_reg.sv
// Operand/result registers with nibble slicing and indexed write-back.
// Latency: operand nibbles are combinational from idx; write-back lands on the next edge.
// Backpressure: none; load and wr are qualified by the owning FSM.
module nibble_lane_reg #(
  parameter int NIBBLES = 4,
  localparam int W  = 4 * NIBBLES,
  localparam int IW = $clog2(NIBBLES)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [W-1:0]  load_a,
  input  logic [W-1:0]  load_b,
  input  logic          wr,
  input  logic [IW-1:0] idx,
  input  logic [3:0]    wr_y,
  output logic [3:0]    a_nib,
  output logic [3:0]    b_nib,
  output logic [W-1:0]  result
);

  logic [W-1:0] a_q;
  logic [W-1:0] b_q;
  logic [W-1:0] res_q;

  // Load clears the result so the previous op never leaks into a new one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
    end else if (load) begin
      a_q   <= load_a;
      b_q   <= load_b;
      res_q <= '0;
    end else if (wr) begin
      res_q[{idx, 2'b00} +: 4] <= wr_y;
    end
  end

  assign a_nib  = a_q[{idx, 2'b00} +: 4];
  assign b_nib  = b_q[{idx, 2'b00} +: 4];
  assign result = res_q;

endmodule

// File: rtl/alu_nibble_seq.sv
// Sequences one wide op through a 4-bit ALU, LSB nibble first, chaining carry/borrow.
// Latency: out_valid rises NIBBLES cycles after the accepting edge; one op per NIBBLES+2 cycles.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready. ALU_NIBBLE_SEQ_OVF_EN adds out_ovf.
module alu_nibble_seq
  import alu_pkg::*;
#(
  parameter int NIBBLES = 4,
  localparam int W = 4 * NIBBLES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic [2:0]   in_op,
  input  logic         in_cin,
  output logic [3:0]   alu_a,
  output logic [3:0]   alu_b,
  output logic [2:0]   alu_sel,
  output logic         alu_cin,
  input  logic [3:0]   alu_y,
  input  logic         alu_cout,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_y,
  output logic         out_cout,
  output logic         out_zero
`ifdef ALU_NIBBLE_SEQ_OVF_EN
  ,
  output logic         out_ovf
`endif
);

  localparam int IW = $clog2(NIBBLES);
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  seq_state_t    state_q, state_d;
  logic [IW-1:0] idx_q;
  logic [2:0]    op_q;
  logic          carry_q;
  logic          cout_q;
  logic          zero_q;
  logic          accept;
  logic          step;
  logic          last;
  logic [3:0]    a_nib;
  logic [3:0]    b_nib;

  assign accept = in_valid && in_ready;
  assign step   = (state_q == RUN);
  assign last   = (idx_q == LAST);

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and handshake outputs.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = RUN;
      end
      RUN: begin
        if (last) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ALU drive: active only while stepping, parked at zero otherwise.
  always_comb begin
    alu_a   = 4'h0;
    alu_b   = 4'h0;
    alu_sel = 3'b000;
    alu_cin = 1'b0;
    if (step) begin
      alu_a   = a_nib;
      alu_b   = b_nib;
      alu_sel = op_q;
      alu_cin = carry_q & is_arith(op_q);
    end
  end

  // Sequencing state: nibble index, carry chain and result flags.
  // Zero is accumulated nibble by nibble since the result starts cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      op_q    <= 3'b000;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      zero_q  <= 1'b1;
    end else if (accept) begin
      idx_q   <= '0;
      op_q    <= in_op;
      carry_q <= in_cin;
      cout_q  <= 1'b0;
      zero_q  <= 1'b1;
    end else if (step) begin
      idx_q   <= last ? '0 : idx_q + 1'b1;
      carry_q <= alu_cout;
      zero_q  <= zero_q & (alu_y == 4'h0);
      if (last) cout_q <= is_arith(op_q) & alu_cout;
    end
  end

  nibble_lane_reg #(.NIBBLES(NIBBLES)) u_lane (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (accept),
    .load_a (in_a),
    .load_b (in_b),
    .wr     (step),
    .idx    (idx_q),
    .wr_y   (alu_y),
    .a_nib  (a_nib),
    .b_nib  (b_nib),
    .result (out_y)
  );

  assign out_cout = cout_q;
  assign out_zero = zero_q;

`ifdef ALU_NIBBLE_SEQ_OVF_EN
  logic ovf_q;
  logic ovf_d;

  // Signed overflow from the MSB nibble: operand signs are the top bits of the last slice.
  always_comb begin
    ovf_d = 1'b0;
    if (op_q == OP_ADD)
      ovf_d = (a_nib[3] == b_nib[3]) && (alu_y[3] != a_nib[3]);
    else if (op_q == OP_SUB)
      ovf_d = (a_nib[3] != b_nib[3]) && (alu_y[3] != a_nib[3]);
  end

  // Overflow flag captured alongside the final nibble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             ovf_q <= 1'b0;
    else if (accept)        ovf_q <= 1'b0;
    else if (step && last)  ovf_q <= ovf_d;
  end

  assign out_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_alu_nibble_seq.sv
`timescale 1ns/1ps
module tb_alu_nibble_seq;

  localparam int NIBBLES = 4;
  localparam int W = 4 * NIBBLES;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic [2:0]   in_op = 3'b000;
  logic         in_cin = 1'b0;
  logic [3:0]   alu_a, alu_b;
  logic [2:0]   alu_sel;
  logic         alu_cin;
  logic [3:0]   alu_y;
  logic         alu_cout;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_y;
  logic         out_cout;
  logic         out_zero;
`ifdef ALU_NIBBLE_SEQ_OVF_EN
  logic         out_ovf;
`endif

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_nibble_seq #(.NIBBLES(NIBBLES)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_cin(in_cin),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_cin(alu_cin),
    .alu_y(alu_y), .alu_cout(alu_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .out_cout(out_cout), .out_zero(out_zero)
`ifdef ALU_NIBBLE_SEQ_OVF_EN
    , .out_ovf(out_ovf)
`endif
  );

  // External 4-bit ALU.
  always_comb begin
    alu_y = 4'h0;
    alu_cout = 1'b0;
    case (alu_sel)
      3'b000: alu_y = ~alu_a;
      3'b010: alu_y = alu_a & alu_b;
      3'b100: alu_y = alu_a | alu_b;
      3'b110: alu_y = alu_a ^ alu_b;
      3'b001: {alu_cout, alu_y} = {1'b0, alu_a} + {1'b0, alu_b} + {4'b0, alu_cin};
      3'b011: begin
        alu_y = alu_a - alu_b - {3'b0, alu_cin};
        alu_cout = ({1'b0, alu_a} < ({1'b0, alu_b} + {4'b0, alu_cin}));
      end
      default: ;
    endcase
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Wide reference: returns {ovf, cout, y}.
  function automatic logic [W+1:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [2:0] op, input logic cin);
    logic [W:0] s;
    logic [W-1:0] y;
    logic c, v;
    y = '0; c = 1'b0; v = 1'b0; s = '0;
    case (op)
      3'b000: y = ~a;
      3'b010: y = a & b;
      3'b100: y = a | b;
      3'b110: y = a ^ b;
      3'b001: begin
        s = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        y = s[W-1:0];
        c = s[W];
        v = (a[W-1] == b[W-1]) && (y[W-1] != a[W-1]);
      end
      3'b011: begin
        y = a - b - {{(W-1){1'b0}}, cin};
        c = ({1'b0, a} < ({1'b0, b} + {{W{1'b0}}, cin}));
        v = (a[W-1] != b[W-1]) && (y[W-1] != a[W-1]);
      end
      default: ;
    endcase
    return {v, c, y};
  endfunction

  // Carry/borrow entering nibble k, from the low 4k bits of the operands.
  function automatic logic chain_in(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic [2:0] op, input logic cin, input int k);
    longint unsigned mask, ma, mb, s;
    mask = (64'd1 << (4 * k)) - 64'd1;
    ma = 64'(a) & mask;
    mb = 64'(b) & mask;
    if (op == 3'b001) begin
      s = ma + mb + 64'(cin);
      return ((s >> (4 * k)) & 64'd1) != 64'd0;
    end
    if (op == 3'b011) return ma < (mb + 64'(cin));
    return 1'b0;
  endfunction

  // Behavioural model + per-cycle compare at the falling edge.
  int           m_ph = 0;   // 0 idle, 1 issuing nibbles, 2 result presented
  int           m_k = 0;
  logic [W-1:0] m_a = '0, m_b = '0, m_y_last = '0;
  logic [2:0]   m_op = 3'b000;
  logic         m_cin = 1'b0;
  logic [W+1:0] m_exp = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_ph = 0;
      m_k = 0;
      m_y_last = '0;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_y", out_y, 0);
      chk("rst_out_cout", out_cout, 0);
      chk("rst_out_zero", out_zero, 1);
      chk("rst_alu", {alu_a, alu_b, alu_sel, alu_cin}, 0);
`ifdef ALU_NIBBLE_SEQ_OVF_EN
      chk("rst_out_ovf", out_ovf, 0);
`endif
    end else begin
      chk("in_ready", in_ready, m_ph == 0);
      chk("out_valid", out_valid, m_ph == 2);
      if (m_ph == 1) begin
        chk("alu_a", alu_a, (m_a >> (4 * m_k)) & 16'hF);
        chk("alu_b", alu_b, (m_b >> (4 * m_k)) & 16'hF);
        chk("alu_sel", alu_sel, m_op);
        chk("alu_cin", alu_cin, chain_in(m_a, m_b, m_op, m_cin, m_k));
      end else begin
        chk("alu_idle", {alu_a, alu_b, alu_sel, alu_cin}, 0);
      end
      if (m_ph == 2) begin
        chk("out_y", out_y, m_exp[W-1:0]);
        chk("out_cout", out_cout, m_exp[W]);
        chk("out_zero", out_zero, m_exp[W-1:0] == '0);
`ifdef ALU_NIBBLE_SEQ_OVF_EN
        chk("out_ovf", out_ovf, m_exp[W+1]);
`endif
      end
      if (m_ph == 0) begin
        chk("held_y", out_y, m_y_last);
        chk("held_zero", out_zero, m_y_last == '0);
      end
      case (m_ph)
        0: if (in_valid) begin
          m_a = in_a; m_b = in_b; m_op = in_op; m_cin = in_cin;
          m_exp = ref_op(in_a, in_b, in_op, in_cin);
          m_k = 0;
          m_ph = 1;
        end
        1: begin
          m_k++;
          if (m_k == NIBBLES) m_ph = 2;
        end
        default: if (out_ready) begin
          m_y_last = m_exp[W-1:0];
          m_ph = 0;
        end
      endcase
    end
  end

  // Drive a request, wait for the result, check against literal expectations.
  task automatic run_op(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2:0] op, input logic cin,
                        input logic [W-1:0] ey, input logic ecout, input logic ezero);
    int waited;
    int lat;
    @(posedge clk); #1;
    in_valid = 1'b1; in_a = a; in_b = b; in_op = op; in_cin = cin;
    waited = 0;
    while (!in_ready && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    chk({nm, "_accept_timeout"}, waited < 50, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      if (op != 3'b001 && op != 3'b011) chk({nm, "_logic_cin"}, alu_cin, 0);
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, "_latency"}, lat, 4);
    chk({nm, "_y"}, out_y, ey);
    chk({nm, "_cout"}, out_cout, ecout);
    chk({nm, "_zero"}, out_zero, ezero);
  endtask

  function automatic logic [W-1:0] rnd_val();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return 16'h8000;
      3: return 16'h7FFF;
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    int waited;
    logic took;
    #12;
    rst_n = 1'b1;

    run_op("add_12ff", 16'h12FF, 16'h0001, 3'b001, 1'b0, 16'h1300, 1'b0, 1'b0);
    run_op("add_ffff_cin", 16'hFFFF, 16'h0000, 3'b001, 1'b1, 16'h0000, 1'b1, 1'b1);
`ifdef ALU_NIBBLE_SEQ_OVF_EN
    run_op("add_ovf", 16'h7FFF, 16'h0001, 3'b001, 1'b0, 16'h8000, 1'b0, 1'b0);
    chk("add_ovf_flag", out_ovf, 1);
`endif
    run_op("sub_0100", 16'h0100, 16'h0001, 3'b011, 1'b0, 16'h00FF, 1'b0, 1'b0);
    run_op("sub_0000", 16'h0000, 16'h0001, 3'b011, 1'b0, 16'hFFFF, 1'b1, 1'b0);
    run_op("not_a5f0", 16'hA5F0, 16'h0000, 3'b000, 1'b1, 16'h5A0F, 1'b0, 1'b0);
    run_op("op_111", 16'h1234, 16'h5678, 3'b111, 1'b1, 16'h0000, 1'b0, 1'b1);

    // Backpressure in DONE with a second request pending.
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid = 1'b1; in_a = 16'h0001; in_b = 16'h0002; in_op = 3'b001; in_cin = 1'b0;
    waited = 0;
    while (!in_ready && waited < 50) begin @(posedge clk); #1; waited++; end
    @(posedge clk); #1;
    in_a = 16'h00F0; in_b = 16'h000F; in_op = 3'b100;
    waited = 0;
    while (!out_valid && waited < 20) begin @(posedge clk); #1; waited++; end
    chk("bp_wait_valid", out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid_held", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_y_held", out_y, 16'h0003);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", out_valid, 0);
    chk("bp_release_ready", in_ready, 1);
    @(posedge clk); #1;
    chk("bp_pending_taken", in_ready, 0);
    in_valid = 1'b0;
    waited = 0;
    while (!out_valid && waited < 20) begin @(posedge clk); #1; waited++; end
    chk("bp_pending_y", out_y, 16'h00FF);
    chk("bp_pending_cout", out_cout, 0);

    // Asynchronous reset while the third nibble is being issued.
    @(posedge clk); #1;
    in_valid = 1'b1; in_a = 16'h1111; in_b = 16'h2222; in_op = 3'b001; in_cin = 1'b0;
    waited = 0;
    while (!in_ready && waited < 50) begin @(posedge clk); #1; waited++; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    chk("pre_rst_alu_a", alu_a, 4'h1);
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_in_ready", in_ready, 1);
    chk("arst_out_y", out_y, 0);
    chk("arst_out_zero", out_zero, 1);
    chk("arst_alu_a", alu_a, 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("post_rst_no_valid", out_valid, 0);
    end
    run_op("add_after_rst", 16'h0F0F, 16'h0101, 3'b001, 1'b0, 16'h1010, 1'b0, 1'b0);

    // Randomized traffic with random backpressure; the model checks every cycle.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      took = in_valid && in_ready;
      @(posedge clk); #1;
      if (!in_valid || took) begin
        in_valid = ($urandom_range(0, 2) != 0);
        in_a = rnd_val();
        in_b = rnd_val();
        in_op = 3'($urandom_range(0, 7));
        in_cin = 1'($urandom_range(0, 1));
      end
      out_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (2 * NIBBLES + 4) @(posedge clk);
    #1;
    chk("drain_idle", in_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_nibble_seq.md
Name: alu_nibble_seq

Overview:
- Upstream sequencer for the 4-bit combinational ALU.
- Accepts one wide operation (two NIBBLES*4-bit operands, 3-bit opcode, carry-in) over a valid/ready handshake.
- Issues it to the ALU one nibble per cycle, LSB nibble first, chaining carry/borrow between nibbles.
- Collects the ALU outputs into a wide result and presents it, with carry and zero flags, over a second valid/ready handshake.

Parameters:
NIBBLES, 4, number of 4-bit slices per operand; operand/result width W = 4*NIBBLES; legal range 2..8.

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  request valid
in_ready  output  1  block can accept a request
in_a  input  W  operand A
in_b  input  W  operand B
in_op  input  3  opcode {S1,S0,M}
in_cin  input  1  carry-in (ADD) / borrow-in (SUB)
alu_a  output  4  nibble of A to ALU
alu_b  output  4  nibble of B to ALU
alu_sel  output  3  opcode to ALU
alu_cin  output  1  chained carry to ALU
alu_y  input  4  ALU result nibble (combinational return)
alu_cout  input  1  ALU carry/borrow out
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_y  output  W  wide result
out_cout  output  1  final carry (ADD) / borrow (SUB); 0 for logic ops
out_zero  output  1  out_y == 0

Behaviour:
- Opcodes:
  - 000 NOT A; 010 AND; 100 OR; 110 XOR; 001 ADD A+B+cin; 011 SUB A-B-cin.
  - Any other code yields y=0, cout=0 per nibble, so out_y=0 and out_cout=0.
- Reset (async, rst_n=0):
  - FSM=IDLE.
  - in_ready=1, out_valid=0, out_y=0, out_cout=0, out_zero=1.
  - alu_a=alu_b=0, alu_sel=0, alu_cin=0.
  - Nibble index=0; operand/result registers cleared.
- FSM states IDLE, RUN, DONE:
  - IDLE:
    - in_ready=1.
    - On in_valid&&in_ready at an edge: latch in_a, in_b, in_op, carry_reg<=in_cin; idx<=0; clear result register; go to RUN.
  - RUN:
    - in_ready=0.
    - Combinationally drive alu_a=a_reg[4*idx+:4], alu_b=b_reg[4*idx+:4], alu_sel=op_reg.
    - alu_cin=carry_reg if op_reg is ADD/SUB, else 0.
    - Each edge: result[4*idx+:4]<=alu_y; carry_reg<=alu_cout; idx<=idx+1.
    - When idx==NIBBLES-1, go to DONE on the same edge.
  - DONE:
    - out_valid=1; out_y, out_cout=carry_reg (forced 0 for logic ops) and out_zero stay stable.
    - On out_ready, go to IDLE; out_valid drops the next cycle.
- ALU-side outputs are 0 outside RUN.
- Latency: out_valid rises exactly NIBBLES cycles after the accepting edge. Throughput: one op per NIBBLES+2 cycles with out_ready held high.
- in_valid while in RUN/DONE is ignored (in_ready=0). No request is lost; the upstream must hold it.
- out_ready while not DONE has no effect.
- SUB borrow semantics match the ALU: alu_cout=1 means the nibble borrowed; it chains as the next nibble's cin.
- Reset mid-RUN or mid-DONE: immediate return to reset values; the partial result is discarded and out_valid is never asserted for it.
- out_y, out_cout, out_zero are registered. out_y holds the last result after returning to IDLE, until the next acceptance clears it.

Optional Feature:
- Macro ALU_NIBBLE_SEQ_OVF_EN.
- Defined: adds output port out_ovf (1 bit), registered, valid with out_valid, signed two's-complement overflow from the MSB nibble.
  - ADD: sign(A)==sign(B) && sign(Y)!=sign(A).
  - SUB: sign(A)!=sign(B) && sign(Y)!=sign(A).
  - Logic/invalid ops: 0. Reset value 0.
- Undefined: port absent; no overflow logic.

Decomposition:
- Package alu_pkg holds:
  - Opcode localparams OP_NOT=3'b000, OP_AND=3'b010, OP_OR=3'b100, OP_XOR=3'b110, OP_ADD=3'b001, OP_SUB=3'b011.
  - Enum typedef seq_state_t {IDLE, RUN, DONE}.
  - Function is_arith(op).
- One natural sub-module, nibble_lane_reg: operand/result nibble slicing and write-back by index.
- FSM and handshakes stay in the top.

Test Plan:
- Accept ADD, A=0x12FF, B=0x0001, cin=0 -> out_valid exactly 4 cycles after acceptance; out_y=0x1300, cout=0, zero=0.
- ADD A=0xFFFF, B=0x0000, cin=1 -> out_y=0x0000, cout=1, zero=1. With the macro: ADD 0x7FFF+0x0001 -> out_ovf=1.
- SUB 0x0100-0x0001, cin=0 -> 0x00FF, cout=0. SUB 0x0000-0x0001 -> 0xFFFF, cout=1.
- NOT A=0xA5F0, cin=1 -> 0x5A0F, cout=0, and alu_cin stays 0 every RUN cycle. Op 3'b111 -> out_y=0x0000, cout=0, zero=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE with in_valid=1 -> outputs stable, in_ready=0. Release -> IDLE next cycle, then the pending request is accepted.
- Assert rst_n=0 asynchronously mid-RUN (idx=2) -> outputs at reset values immediately, no out_valid; a new ADD then completes correctly.
